seq_multiply: RTL

//  Parametrised sequential shift-add multiplier; successor to the fixed 9x9 combinational multiply.

---
 rtl/seq_multiply.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_multiply.sv
// Sequential shift-add multiplier with valid/ready handshakes.
// Operands are reduced to magnitudes at acceptance. A single WIDTH+1 bit adder is then
// iterated WIDTH times. The sign is re-applied when the full 2*WIDTH product is registered.
module seq_multiply #(
  parameter int unsigned WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CntOne  = CW'(1);
  localparam logic [CW-1:0]      CntLast = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   OneW    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] OneP    = (2 * WIDTH)'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    acc_q;     // high half of the running product
  logic [WIDTH-1:0]    mplier_q;  // multiplier, shifted out as product low bits shift in
  logic                neg_q;
  logic [CW-1:0]       count_q;
  logic [2*WIDTH-1:0]  p_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  prod_full;
  logic [2*WIDTH-1:0]  prod_neg;

  // Operand magnitudes, partial-sum adder and the final product for the last iteration.
  always_comb begin
    mag_a     = (is_signed && A[WIDTH-1]) ? ((~A) + OneW) : A;
    mag_b     = (is_signed && B[WIDTH-1]) ? ((~B) + OneW) : B;
    sum       = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    // Product after the final shift: carry-kept sum on top, remaining multiplier bits below.
    prod_full = {sum, mplier_q[WIDTH-1:1]};
    prod_neg  = (~prod_full) + OneP;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      count_q     <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q    <= mag_a;
            mplier_q   <= mag_b;
            acc_q      <= '0;
            neg_q      <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          acc_q    <= sum[WIDTH:1];
          mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
          count_q  <= count_q + CntOne;
          if (count_q == CntLast) begin
            p_q         <= neg_q ? prod_neg : prod_full;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule
